crcu_apb_regs: RTL and testbench

CRCU_APB_REGS -- requirements
Module: crcu_apb_regs

---
 rtl/crcu_apb_pkg.sv | 51 +++++
 rtl/crcu_sticky_status.sv | 29 ++
 rtl/crcu_apb_regs.sv | 126 ++++++++++++
 tb/tb_crcu_apb_regs.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/crcu_apb_pkg.sv
// rtl/crcu_apb_pkg.sv - register map, reset values and FSM encoding for the CRCU APB register block
package crcu_apb_pkg;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h4352_0100;

  localparam logic [7:0] OFF_WD_IOL_RST_CTL = 8'h00;
  localparam logic [7:0] OFF_SYS_RST_CTL    = 8'h04;
  localparam logic [7:0] OFF_CLK_GATE_CTL   = 8'h08;
  localparam logic [7:0] OFF_RST_STATUS     = 8'h0C;
  localparam logic [7:0] OFF_LOCK           = 8'h10;
  localparam logic [7:0] OFF_ID             = 8'h14;

  localparam logic [31:0] RST_WD_IOL_RST_CTL = 32'h0000_0000;
  localparam logic [31:0] RST_SYS_RST_CTL    = 32'h0000_0000;
  localparam logic [31:0] RST_CLK_GATE_CTL   = 32'h0000_0000;
  localparam logic [7:0]  RST_RST_STATUS     = 8'h00;
  localparam logic        RST_LOCK           = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT,
    RESP
  } crcu_state_e;

  typedef enum logic [2:0] {
    REG_WD,
    REG_SYS,
    REG_CG,
    REG_STATUS,
    REG_LOCK,
    REG_ID,
    REG_NONE
  } crcu_reg_e;

  // Misaligned offsets fall through to REG_NONE because no mapped offset has low bits set.
  function automatic crcu_reg_e decode_offset(input logic [7:0] off);
    crcu_reg_e r;
    case (off)
      OFF_WD_IOL_RST_CTL: r = REG_WD;
      OFF_SYS_RST_CTL:    r = REG_SYS;
      OFF_CLK_GATE_CTL:   r = REG_CG;
      OFF_RST_STATUS:     r = REG_STATUS;
      OFF_LOCK:           r = REG_LOCK;
      OFF_ID:             r = REG_ID;
      default:            r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/crcu_sticky_status.sv
// rtl/crcu_sticky_status.sv - 8-bit sticky status bank, write-1-to-clear with set priority
module crcu_sticky_status (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] set_i,
  input  logic [7:0] clr_i,
  output logic [7:0] status_o
);
  import crcu_apb_pkg::*;

  logic [7:0] status_q;
  logic [7:0] status_d;

  // An event arriving on the same edge as a clear wins, so no pulse is ever lost.
  always_comb begin
    status_d = (status_q & ~clr_i) | set_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      status_q <= RST_RST_STATUS;
    end else begin
      status_q <= status_d;
    end
  end

  assign status_o = status_q;

endmodule

// File: rtl/crcu_apb_regs.sv
// rtl/crcu_apb_regs.sv - APB register block for reset/clock-gate control with lock and sticky status
module crcu_apb_regs
  import crcu_apb_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT
) (
  input  logic              CRCU_CLK,
  input  logic              CRCU_RST,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [7:0]        rst_event_in,
  output logic [31:0]       wd_iol_rst_ctl_reg,
  output logic [31:0]       sys_rst_ctl_reg,
  output logic [31:0]       clk_gate_ctl_reg
);

  crcu_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [31:0] wd_q, sys_q, cg_q;
  logic        lock_q;
  logic [7:0]  status;
  logic [7:0]  status_clr;

  crcu_reg_e   reg_sel;
  logic        hi_zero;
  logic        is_ctrl;
  logic        xfer_err;
  logic        commit;
  logic [31:0] rd_val;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = SETUP;
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
        end
      end
      SETUP:   state_d = (psel && penable) ? WAIT : IDLE;
      WAIT:    state_d = psel ? RESP : IDLE;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address bits above the 8-bit offset space must be zero for a hit.
  always_comb begin
    hi_zero = (ADDR_W <= 8) ? 1'b1 : ((addr_q >> 8) == '0);
    reg_sel = hi_zero ? decode_offset(8'(addr_q)) : REG_NONE;
    is_ctrl = (reg_sel == REG_WD) || (reg_sel == REG_SYS) || (reg_sel == REG_CG);
    xfer_err = (reg_sel == REG_NONE)
             || (write_q && (reg_sel == REG_ID))
             || (write_q && lock_q && is_ctrl);
    commit = (state_q == RESP) && write_q && !xfer_err;
  end

  always_comb begin
    rd_val = 32'h0;
    case (reg_sel)
      REG_WD:     rd_val = wd_q;
      REG_SYS:    rd_val = sys_q;
      REG_CG:     rd_val = cg_q;
      REG_STATUS: rd_val = {24'h0, status};
      REG_LOCK:   rd_val = {31'h0, lock_q};
      REG_ID:     rd_val = ID_VALUE;
      default:    rd_val = 32'h0;
    endcase
  end

  assign status_clr = (commit && (reg_sel == REG_STATUS)) ? wdata_q[7:0] : 8'h00;

  always_ff @(posedge CRCU_CLK) begin
    if (CRCU_RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= 32'h0;
      wd_q    <= RST_WD_IOL_RST_CTL;
      sys_q   <= RST_SYS_RST_CTL;
      cg_q    <= RST_CLK_GATE_CTL;
      lock_q  <= RST_LOCK;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      if (commit && (reg_sel == REG_WD))  wd_q  <= wdata_q;
      if (commit && (reg_sel == REG_SYS)) sys_q <= wdata_q;
      if (commit && (reg_sel == REG_CG))  cg_q  <= wdata_q;
      if (commit && (reg_sel == REG_LOCK) && wdata_q[0]) lock_q <= 1'b1;
    end
  end

  crcu_sticky_status u_sticky (
    .clk_i    (CRCU_CLK),
    .rst_i    (CRCU_RST),
    .set_i    (rst_event_in),
    .clr_i    (status_clr),
    .status_o (status)
  );

  assign pready  = (state_q == RESP);
  assign pslverr = (state_q == RESP) && xfer_err;
  assign prdata  = ((state_q == RESP) && !write_q && !xfer_err) ? rd_val : 32'h0;

  assign wd_iol_rst_ctl_reg = wd_q;
  assign sys_rst_ctl_reg    = sys_q;
  assign clk_gate_ctl_reg   = cg_q;

endmodule

// File: tb/tb_crcu_apb_regs.sv
// tb/tb_crcu_apb_regs.sv - self-checking bench for crcu_apb_regs against a register-map model
module tb_crcu_apb_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [7:0]  paddr = 8'h0;
  logic [31:0] pwdata = 32'h0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [7:0]  rst_event_in = 8'h0;
  logic [31:0] wd_reg, sys_reg, cg_reg;

  int n_checks = 0;
  int n_err = 0;

  logic [31:0] m_wd, m_sys, m_cg;
  logic [7:0]  m_status;
  logic        m_lock;

  always #5 clk = ~clk;

  crcu_apb_regs #(.ADDR_W(8), .ID_VALUE(32'h4352_0100)) dut (
    .CRCU_CLK           (clk),
    .CRCU_RST           (rst),
    .psel               (psel),
    .penable            (penable),
    .pwrite             (pwrite),
    .paddr              (paddr),
    .pwdata             (pwdata),
    .prdata             (prdata),
    .pready             (pready),
    .pslverr            (pslverr),
    .rst_event_in       (rst_event_in),
    .wd_iol_rst_ctl_reg (wd_reg),
    .sys_rst_ctl_reg    (sys_reg),
    .clk_gate_ctl_reg   (cg_reg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_err(input logic wr, input logic [7:0] a);
    bit mapped;
    mapped = (a == 8'h00) || (a == 8'h04) || (a == 8'h08) ||
             (a == 8'h0C) || (a == 8'h10) || (a == 8'h14);
    if (!mapped) return 1'b1;
    if (wr && a == 8'h14) return 1'b1;
    if (wr && m_lock && a <= 8'h08) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h00:   return m_wd;
      8'h04:   return m_sys;
      8'h08:   return m_cg;
      8'h0C:   return {24'h0, m_status};
      8'h10:   return {31'h0, m_lock};
      8'h14:   return 32'h4352_0100;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_wd = 0; m_sys = 0; m_cg = 0; m_status = 0; m_lock = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; psel = 1'b0; penable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_reset();
    @(negedge clk);
  endtask

  task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic err);
    int lat;
    bit got;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    lat = 1;
    got = 0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (pready) got = 1;
    end
    chk("pready_latency", lat, 3);
    rd = prdata;
    err = pslverr;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("pready_single_cycle", {31'h0, pready}, 0);
  endtask

  task automatic op(input logic wr, input logic [7:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic        err;
    bit          e_err;
    logic [31:0] e_rd;
    m_status = m_status | rst_event_in;
    e_err = m_err(wr, a);
    e_rd  = (wr || e_err) ? 32'h0 : m_read(a);
    xfer(wr, a, d, rd, err);
    chk("pslverr", {31'h0, err}, {31'h0, e_err});
    if (!wr) chk("prdata", rd, e_rd);
    if (wr && !e_err) begin
      case (a)
        8'h00: m_wd = d;
        8'h04: m_sys = d;
        8'h08: m_cg = d;
        8'h0C: m_status = m_status & ~d[7:0];
        8'h10: if (d[0]) m_lock = 1'b1;
        default: ;
      endcase
    end
    m_status = m_status | rst_event_in;
    chk("wd_iol_rst_ctl_reg", wd_reg, m_wd);
    chk("sys_rst_ctl_reg", sys_reg, m_sys);
    chk("clk_gate_ctl_reg", cg_reg, m_cg);
  endtask

  initial begin
    logic [7:0] addrs [9];
    logic [7:0] a;
    logic       wr;
    logic [31:0] d;
    bit         seen;
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h02, 8'h40, 8'h00};

    do_reset();
    chk("reset_pready", {31'h0, pready}, 0);
    chk("reset_pslverr", {31'h0, pslverr}, 0);
    chk("reset_prdata", prdata, 0);
    chk("reset_wd", wd_reg, 0);
    chk("reset_sys", sys_reg, 0);
    chk("reset_cg", cg_reg, 0);
    op(1'b0, 8'h0C, 0);
    op(1'b0, 8'h10, 0);

    op(1'b1, 8'h00, 32'h0000_0007);
    op(1'b0, 8'h00, 0);

    op(1'b0, 8'h14, 0);
    op(1'b1, 8'h14, 32'hDEAD_BEEF);
    op(1'b0, 8'h14, 0);

    op(1'b0, 8'h02, 0);
    op(1'b1, 8'h02, 32'h1234_5678);
    op(1'b0, 8'h40, 0);
    op(1'b1, 8'h40, 32'h1111_1111);

    @(negedge clk); rst_event_in = 8'h08;
    @(negedge clk); rst_event_in = 8'h00;
    m_status = m_status | 8'h08;
    op(1'b0, 8'h0C, 0);
    rst_event_in = 8'h08;
    op(1'b1, 8'h0C, 32'h0000_0008);
    rst_event_in = 8'h00;
    op(1'b0, 8'h0C, 0);
    @(negedge clk); rst_event_in = 8'h21;
    @(negedge clk); rst_event_in = 8'h00;
    m_status = m_status | 8'h21;
    op(1'b1, 8'h0C, 32'h0000_0009);
    op(1'b0, 8'h0C, 0);

    for (int i = 0; i < 40; i++) begin
      a  = ($urandom_range(0, 9) == 9) ? 8'($urandom) : addrs[$urandom_range(0, 8)];
      wr = 1'($urandom);
      d  = $urandom;
      if (a == 8'h10 && $urandom_range(0, 3) != 0) d[0] = 1'b0;
      op(wr, a, d);
    end

    do_reset();
    op(1'b1, 8'h10, 32'h0000_0001);
    op(1'b1, 8'h04, 32'h0000_0005);
    op(1'b0, 8'h04, 0);
    op(1'b1, 8'h10, 32'h0000_0000);
    op(1'b0, 8'h10, 0);

    do_reset();
    op(1'b1, 8'h08, 32'h0000_00A5);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h0000_0033;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    @(negedge clk);
    if (pready) seen = 1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    m_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (pready) seen = 1;
    end
    chk("abort_no_pready", {31'h0, seen}, 0);
    chk("abort_cg_zero", cg_reg, 0);
    op(1'b0, 8'h08, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
